// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, owns the PC,
// and fills the IF/ID register, with a one-entry skid for fetches that land during a stall.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemAck,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD,
    output logic [1:0]               o_FsmState
);

    // Memory handshake: o_IMemReq is a level held high with o_IMemAddr stable
    // until the cycle i_IMemAck is seen; i_IMemRdata is valid only in that cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     pending_q, pending_d;
    logic [ADDRESS_WIDTH-1:0] redir_q, redir_d;
    logic [INSTR_WIDTH-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDRESS_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
    logic [INSTR_WIDTH-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDRESS_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic                     ifid_valid_q, ifid_valid_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     redirect;

    assign pc_plus4 = pc_q + PC_STEP;
    assign redirect = i_PCSrcD && !i_StallD;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            redir_q      <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            redir_q      <= redir_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        redir_d      = redir_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (!i_StallD) begin
                    ifid_instr_d = '0;
                    ifid_pc4_d   = '0;
                    ifid_valid_d = 1'b0;
                end
            end

            FETCH: begin
                if (i_IMemAck) begin
                    if (pending_q) begin
                        // Wrong-path word: drop it and jump to the newest target.
                        pending_d = 1'b0;
                        pc_d      = redirect ? i_PCD : redir_q;
                        if (!i_StallD) begin
                            ifid_instr_d = '0;
                            ifid_pc4_d   = '0;
                            ifid_valid_d = 1'b0;
                        end
                    end else if (i_StallD) begin
                        skid_instr_d = i_IMemRdata;
                        skid_pc4_d   = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = HOLD;
                    end else if (i_PCSrcD) begin
                        pc_d         = i_PCD;
                        ifid_instr_d = '0;
                        ifid_pc4_d   = '0;
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_instr_d = i_IMemRdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end
                end else if (!i_StallD) begin
                    // Address must stay put until ack, so a redirect is parked.
                    ifid_instr_d = '0;
                    ifid_pc4_d   = '0;
                    ifid_valid_d = 1'b0;
                    if (i_PCSrcD) begin
                        pending_d = 1'b1;
                        redir_d   = i_PCD;
                    end
                end
            end

            HOLD: begin
                if (!i_StallD) begin
                    state_d = FETCH;
                    if (i_PCSrcD) begin
                        pc_d         = i_PCD;
                        ifid_instr_d = '0;
                        ifid_pc4_d   = '0;
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc4_d   = skid_pc4_q;
                        ifid_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_IMemReq  = (state_q == FETCH);
    assign o_IMemAddr = pc_q;
    assign o_InstrD   = ifid_instr_q;
    assign o_PCPlus4D = ifid_pc4_q;
    assign o_ValidD   = ifid_valid_q;
    assign o_FsmState = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change on the falling edge, outputs
// are checked on the falling edge after each rising edge.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_StallD;
    logic        i_PCSrcD;
    logic [31:0] i_PCD;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemAck;
    logic [31:0] i_IMemRdata;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCPlus4D;
    logic        o_ValidD;
    logic [1:0]  o_FsmState;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .INSTR_WIDTH  (32),
        .RESET_PC     (RESET_PC)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_StallD   (i_StallD),
        .i_PCSrcD   (i_PCSrcD),
        .i_PCD      (i_PCD),
        .o_IMemReq  (o_IMemReq),
        .o_IMemAddr (o_IMemAddr),
        .i_IMemAck  (i_IMemAck),
        .i_IMemRdata(i_IMemRdata),
        .o_InstrD   (o_InstrD),
        .o_PCPlus4D (o_PCPlus4D),
        .o_ValidD   (o_ValidD),
        .o_FsmState (o_FsmState)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0] ^ 16'h5A5A};
    endfunction

    task automatic step();
        @(negedge i_CLK);
    endtask

    task automatic do_reset();
        i_RST = 1'b0; i_StallD = 1'b0; i_PCSrcD = 1'b0; i_PCD = '0;
        i_IMemAck = 1'b0; i_IMemRdata = '0;
        step(); step();
        i_RST = 1'b1;
    endtask

    // Zero-wait memory for n requests, no stall, no redirect.
    task automatic run_acks(input int n);
        for (int i = 0; i < n; i++) begin
            i_IMemAck = 1'b1; i_IMemRdata = mem_word(o_IMemAddr);
            step();
        end
        i_IMemAck = 1'b0;
    endtask

    task automatic test_reset();
        i_RST = 1'b0; i_StallD = 1'b0; i_PCSrcD = 1'b1; i_PCD = 32'h44;
        i_IMemAck = 1'b1; i_IMemRdata = 32'hDEAD_BEEF;
        step(); step();
        checks++; if (o_IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", o_IMemReq); end
        checks++; if (o_IMemAddr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h exp %h", o_IMemAddr, RESET_PC); end
        checks++; if (o_InstrD !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", o_InstrD); end
        checks++; if (o_PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h exp 0", o_PCPlus4D); end
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", o_ValidD); end
        checks++; if (o_FsmState !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", o_FsmState); end
        i_RST = 1'b1; i_PCSrcD = 1'b0;
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_IMemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %b exp 1", o_IMemReq); end
        checks++; if (o_IMemAddr !== RESET_PC) begin errors++; $display("FAIL first_addr: got %h exp %h", o_IMemAddr, RESET_PC); end
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL first_valid: got %b exp 0", o_ValidD); end
        checks++; if (o_FsmState !== 2'd1) begin errors++; $display("FAIL first_state: got %0d exp 1", o_FsmState); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset(); step();
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            checks++; if (o_IMemAddr !== a) begin errors++; $display("FAIL zw_addr%0d: got %h exp %h", k, o_IMemAddr, a); end
            i_IMemAck = o_IMemReq; i_IMemRdata = mem_word(o_IMemAddr);
            step();
            checks++; if (o_PCPlus4D !== a + 32'd4) begin errors++; $display("FAIL zw_pc4%0d: got %h exp %h", k, o_PCPlus4D, a + 32'd4); end
            checks++; if (o_InstrD !== mem_word(a)) begin errors++; $display("FAIL zw_instr%0d: got %h exp %h", k, o_InstrD, mem_word(a)); end
            checks++; if (o_ValidD !== 1'b1) begin errors++; $display("FAIL zw_valid%0d: got %b exp 1", k, o_ValidD); end
        end
        i_IMemAck = 1'b0;
    endtask

    task automatic test_stall_skid();
        do_reset(); step(); run_acks(2);
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h8); i_StallD = 1'b1;
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_FsmState !== 2'd2) begin errors++; $display("FAIL sk_state: got %0d exp 2", o_FsmState); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_IMemReq !== 1'b0) begin errors++; $display("FAIL sk_req%0d: got %b exp 0", i, o_IMemReq); end
            checks++; if (o_InstrD !== mem_word(32'h4) || o_PCPlus4D !== 32'h8 || o_ValidD !== 1'b1) begin
                errors++; $display("FAIL sk_ifid%0d: got %h/%h/%b exp %h/00000008/1", i, o_InstrD, o_PCPlus4D, o_ValidD, mem_word(32'h4));
            end
            if (i < 2) step();
        end
        i_StallD = 1'b0;
        step();
        checks++; if (o_InstrD !== mem_word(32'h8)) begin errors++; $display("FAIL sk_instr: got %h exp %h", o_InstrD, mem_word(32'h8)); end
        checks++; if (o_PCPlus4D !== 32'hC) begin errors++; $display("FAIL sk_pc4: got %h exp 0000000c", o_PCPlus4D); end
        checks++; if (o_ValidD !== 1'b1) begin errors++; $display("FAIL sk_valid: got %b exp 1", o_ValidD); end
        checks++; if (o_IMemReq !== 1'b1 || o_IMemAddr !== 32'hC) begin errors++; $display("FAIL sk_next: got %b/%h exp 1/0000000c", o_IMemReq, o_IMemAddr); end
    endtask

    task automatic test_redirect_wait();
        do_reset(); step(); run_acks(4);
        i_PCSrcD = 1'b1; i_PCD = 32'h40;
        checks++; if (o_IMemAddr !== 32'h10) begin errors++; $display("FAIL rw_addr0: got %h exp 00000010", o_IMemAddr); end
        step();
        i_PCSrcD = 1'b0;
        checks++; if (o_IMemAddr !== 32'h10 || o_IMemReq !== 1'b1) begin errors++; $display("FAIL rw_hold1: got %h/%b exp 00000010/1", o_IMemAddr, o_IMemReq); end
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL rw_bubble: got %b exp 0", o_ValidD); end
        step();
        checks++; if (o_IMemAddr !== 32'h10) begin errors++; $display("FAIL rw_hold2: got %h exp 00000010", o_IMemAddr); end
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h10);
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_IMemAddr !== 32'h40) begin errors++; $display("FAIL rw_target: got %h exp 00000040", o_IMemAddr); end
        checks++; if (o_ValidD !== 1'b0 || o_InstrD !== 32'h0) begin errors++; $display("FAIL rw_discard: got %b/%h exp 0/00000000", o_ValidD, o_InstrD); end
        run_acks(1);
        checks++; if (o_InstrD !== mem_word(32'h40) || o_PCPlus4D !== 32'h44 || o_ValidD !== 1'b1) begin
            errors++; $display("FAIL rw_new: got %h/%h/%b exp %h/00000044/1", o_InstrD, o_PCPlus4D, o_ValidD, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_ack();
        do_reset(); step(); run_acks(2);
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h8); i_PCSrcD = 1'b1; i_PCD = 32'h100;
        step();
        i_IMemAck = 1'b0; i_PCSrcD = 1'b0;
        checks++; if (o_ValidD !== 1'b0 || o_InstrD !== 32'h0) begin errors++; $display("FAIL ra_bubble: got %b/%h exp 0/00000000", o_ValidD, o_InstrD); end
        checks++; if (o_IMemAddr !== 32'h100) begin errors++; $display("FAIL ra_target: got %h exp 00000100", o_IMemAddr); end
        run_acks(1);
        checks++; if (o_InstrD !== mem_word(32'h100) || o_PCPlus4D !== 32'h104 || o_ValidD !== 1'b1) begin
            errors++; $display("FAIL ra_new: got %h/%h/%b exp %h/00000104/1", o_InstrD, o_PCPlus4D, o_ValidD, mem_word(32'h100));
        end
    endtask

    task automatic test_latest_wins();
        do_reset(); step(); run_acks(2);
        i_PCSrcD = 1'b1; i_PCD = 32'h200;
        step();
        i_PCD = 32'h300;
        step();
        i_StallD = 1'b1; i_PCD = 32'h500;
        step();
        i_StallD = 1'b0; i_PCSrcD = 1'b0;
        checks++; if (o_IMemAddr !== 32'h8 || o_IMemReq !== 1'b1) begin errors++; $display("FAIL lw_hold: got %h/%b exp 00000008/1", o_IMemAddr, o_IMemReq); end
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h8);
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_IMemAddr !== 32'h300) begin errors++; $display("FAIL lw_target: got %h exp 00000300", o_IMemAddr); end
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL lw_bubble: got %b exp 0", o_ValidD); end
    endtask

    task automatic test_hold_redirect();
        do_reset(); step(); run_acks(1);
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h4); i_StallD = 1'b1;
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_FsmState !== 2'd2) begin errors++; $display("FAIL hr_state0: got %0d exp 2", o_FsmState); end
        i_StallD = 1'b0; i_PCSrcD = 1'b1; i_PCD = 32'h80;
        step();
        i_PCSrcD = 1'b0;
        checks++; if (o_FsmState !== 2'd1 || o_IMemAddr !== 32'h80) begin errors++; $display("FAIL hr_target: got %0d/%h exp 1/00000080", o_FsmState, o_IMemAddr); end
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL hr_bubble: got %b exp 0", o_ValidD); end
        run_acks(1);
        checks++; if (o_InstrD !== mem_word(32'h80) || o_PCPlus4D !== 32'h84) begin
            errors++; $display("FAIL hr_new: got %h/%h exp %h/00000084", o_InstrD, o_PCPlus4D, mem_word(32'h80));
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); step(); run_acks(9);
        checks++; if (o_IMemAddr !== 32'h24) begin errors++; $display("FAIL rm_setup: got %h exp 00000024", o_IMemAddr); end
        step();
        i_RST = 1'b0;
        #1;
        checks++; if (o_IMemReq !== 1'b0 || o_ValidD !== 1'b0) begin errors++; $display("FAIL rm_ctl: got %b/%b exp 0/0", o_IMemReq, o_ValidD); end
        checks++; if (o_InstrD !== 32'h0 || o_PCPlus4D !== 32'h0) begin errors++; $display("FAIL rm_data: got %h/%h exp 0/0", o_InstrD, o_PCPlus4D); end
        checks++; if (o_IMemAddr !== RESET_PC) begin errors++; $display("FAIL rm_pc: got %h exp %h", o_IMemAddr, RESET_PC); end
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h24);
        step();
        i_RST = 1'b1;
        step();
        i_IMemAck = 1'b0;
        checks++; if (o_ValidD !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got %b exp 0", o_ValidD); end
        checks++; if (o_IMemReq !== 1'b1 || o_IMemAddr !== RESET_PC) begin errors++; $display("FAIL rm_restart: got %b/%h exp 1/%h", o_IMemReq, o_IMemAddr, RESET_PC); end
        run_acks(1);
        checks++; if (o_InstrD !== mem_word(RESET_PC) || o_PCPlus4D !== RESET_PC + 32'd4 || o_ValidD !== 1'b1) begin
            errors++; $display("FAIL rm_first: got %h/%h/%b exp %h/%h/1", o_InstrD, o_PCPlus4D, o_ValidD, mem_word(RESET_PC), RESET_PC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        do_reset(); step();
        i_IMemAck = 1'b1; i_IMemRdata = mem_word(32'h0); i_PCSrcD = 1'b1; i_PCD = 32'hFFFF_FFFC;
        step();
        i_IMemAck = 1'b0; i_PCSrcD = 1'b0;
        checks++; if (o_IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr: got %h exp fffffffc", o_IMemAddr); end
        run_acks(1);
        checks++; if (o_PCPlus4D !== 32'h0) begin errors++; $display("FAIL wr_pc4: got %h exp 00000000", o_PCPlus4D); end
        checks++; if (o_InstrD !== mem_word(32'hFFFF_FFFC) || o_ValidD !== 1'b1) begin
            errors++; $display("FAIL wr_instr: got %h/%b exp %h/1", o_InstrD, o_ValidD, mem_word(32'hFFFF_FFFC));
        end
        checks++; if (o_IMemAddr !== 32'h0) begin errors++; $display("FAIL wr_next: got %h exp 00000000", o_IMemAddr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_ack();
        test_latest_wins();
        test_hold_redirect();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
